// File: rtl/regfile_sb.sv
// Integer register file with two write ports (A: execute, B: load) and a busy
// scoreboard tracking outstanding loads; x0 is hardwired to zero.
module regfile_sb #(
    parameter int  XLEN     = 32,
    parameter int  NUM_REGS = 32,
    parameter bit  BYPASS   = 1'b1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   rd_a,
    input  logic [XLEN-1:0]     wdata_a,
    input  logic                we_a_L,
    input  logic [ADDR_W-1:0]   rd_b,
    input  logic [XLEN-1:0]     wdata_b,
    input  logic                we_b_L,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_L,
    input  logic [ADDR_W-1:0]   rs1,
    output logic [XLEN-1:0]     regData1,
    input  logic [ADDR_W-1:0]   rs2,
    output logic [XLEN-1:0]     regData2,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [XLEN-1:0]     bank_q [NUM_REGS];
    logic [XLEN-1:0]     bank_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic wr_a;
    logic wr_b;
    logic iss;

    assign wr_a = !we_a_L  && (rd_a     != '0);
    assign wr_b = !we_b_L  && (rd_b     != '0);
    assign iss  = !issue_L && (issue_rd != '0);

    // Port A is applied last so it wins a same-register collision; likewise
    // a new issue overrides the port-B clear of the load it replaces.
    always_comb begin
        bank_d = bank_q;
        busy_d = busy_q;
        if (wr_b) bank_d[rd_b] = wdata_b;
        if (wr_a) bank_d[rd_a] = wdata_a;
        if (!we_b_L) busy_d[rd_b] = 1'b0;
        if (iss) busy_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            bank_q <= bank_d;
            busy_q <= busy_d;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [ADDR_W-1:0] rs);
        logic [XLEN-1:0] val;
        if (!reset || rs == '0)               val = '0;
        else if (BYPASS && wr_a && rd_a == rs) val = wdata_a;
        else if (BYPASS && wr_b && rd_b == rs) val = wdata_b;
        else                                   val = bank_q[rs];
        return val;
    endfunction

    // A load completing this cycle already satisfies the reader via bypass.
    function automatic logic busy_port(input logic [ADDR_W-1:0] rs);
        return reset && busy_q[rs] && !(BYPASS && !we_b_L && rd_b == rs);
    endfunction

    always_comb begin
        regData1 = read_port(rs1);
        regData2 = read_port(rs2);
        rs1_busy = busy_port(rs1);
        rs2_busy = busy_port(rs2);
        busy_vec = reset ? busy_q : '0;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: BYPASS=1 and BYPASS=0 instances share stimulus and are
// compared every cycle against an array-based reference model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int AW   = 5;

    logic            clock;
    logic            reset;
    logic [AW-1:0]   rd_a, rd_b, issue_rd, rs1, rs2;
    logic [XLEN-1:0] wdata_a, wdata_b;
    logic            we_a_L, we_b_L, issue_L;

    logic [XLEN-1:0] d1_r1, d1_r2, d0_r1, d0_r2;
    logic            d1_b1, d1_b2, d0_b1, d0_b2;
    logic [NR-1:0]   d1_bv, d0_bv;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    logic [XLEN-1:0] m_bank [NR];
    bit              m_busy [NR];

    regfile_sb #(.XLEN(XLEN), .NUM_REGS(NR), .BYPASS(1'b1)) dut1 (
        .clock(clock), .reset(reset),
        .rd_a(rd_a), .wdata_a(wdata_a), .we_a_L(we_a_L),
        .rd_b(rd_b), .wdata_b(wdata_b), .we_b_L(we_b_L),
        .issue_rd(issue_rd), .issue_L(issue_L),
        .rs1(rs1), .regData1(d1_r1), .rs2(rs2), .regData2(d1_r2),
        .rs1_busy(d1_b1), .rs2_busy(d1_b2), .busy_vec(d1_bv)
    );

    regfile_sb #(.XLEN(XLEN), .NUM_REGS(NR), .BYPASS(1'b0)) dut0 (
        .clock(clock), .reset(reset),
        .rd_a(rd_a), .wdata_a(wdata_a), .we_a_L(we_a_L),
        .rd_b(rd_b), .wdata_b(wdata_b), .we_b_L(we_b_L),
        .issue_rd(issue_rd), .issue_L(issue_L),
        .rs1(rs1), .regData1(d0_r1), .rs2(rs2), .regData2(d0_r2),
        .rs1_busy(d0_b1), .rs2_busy(d0_b2), .busy_vec(d0_bv)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sequential register array plus busy flags.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NR; i++) begin
                m_bank[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (!we_b_L && rd_b != 0) m_bank[rd_b] = wdata_b;
            if (!we_a_L && rd_a != 0) m_bank[rd_a] = wdata_a;
            if (!we_b_L) m_busy[rd_b] = 1'b0;
            if (!issue_L && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    end

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] rs, input bit byp);
        if (!reset || rs == 0) return '0;
        if (byp && !we_a_L && rd_a == rs) return wdata_a;
        if (byp && !we_b_L && rd_b == rs) return wdata_b;
        return m_bank[rs];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] rs, input bit byp);
        if (!reset) return 1'b0;
        return m_busy[rs] && !(byp && !we_b_L && rd_b == rs);
    endfunction

    function automatic logic [NR-1:0] exp_vec();
        logic [NR-1:0] v = '0;
        if (reset) for (int i = 0; i < NR; i++) v[i] = m_busy[i];
        return v;
    endfunction

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("b1_regData1", d1_r1, exp_rd(rs1, 1'b1));
            chk("b1_regData2", d1_r2, exp_rd(rs2, 1'b1));
            chk("b1_rs1_busy", 32'(d1_b1), 32'(exp_busy(rs1, 1'b1)));
            chk("b1_rs2_busy", 32'(d1_b2), 32'(exp_busy(rs2, 1'b1)));
            chk("b1_busy_vec", d1_bv, exp_vec());
            chk("b0_regData1", d0_r1, exp_rd(rs1, 1'b0));
            chk("b0_regData2", d0_r2, exp_rd(rs2, 1'b0));
            chk("b0_rs1_busy", 32'(d0_b1), 32'(exp_busy(rs1, 1'b0)));
            chk("b0_rs2_busy", 32'(d0_b2), 32'(exp_busy(rs2, 1'b0)));
            chk("b0_busy_vec", d0_bv, exp_vec());
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        we_a_L = 1'b1; we_b_L = 1'b1; issue_L = 1'b1;
        rd_a = '0; rd_b = '0; issue_rd = '0;
        wdata_a = '0; wdata_b = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        rs1 = '0; rs2 = '0;

        // Reset held with a pending port-A write.
        we_a_L = 1'b0; rd_a = 5; wdata_a = 32'hDEADBEEF; rs1 = 5;
        cyc();
        cmp_en = 1;
        mid();
        chk("rst_hold_rd1", d1_r1, 32'h0);
        cyc();
        reset = 1'b1; idle(); rs1 = 5;
        mid();
        chk("rst_rel_rd1", d1_r1, 32'h0);
        chk("rst_rel_vec", d1_bv, 32'h0);

        // Dual write to x3: A wins, both in bypass and in the bank.
        cyc();
        we_a_L = 0; rd_a = 3; wdata_a = 32'h11111111;
        we_b_L = 0; rd_b = 3; wdata_b = 32'h22222222; rs1 = 3;
        mid();
        chk("dual_bypass", d1_r1, 32'h11111111);
        cyc();
        idle(); rs1 = 3;
        mid();
        chk("dual_bank_b1", d1_r1, 32'h11111111);
        chk("dual_bank_b0", d0_r1, 32'h11111111);

        cyc();
        we_a_L = 0; rd_a = 7; wdata_a = 32'hA5A5A5A5; rs2 = 7;
        mid();
        chk("bypass_rd2", d1_r2, 32'hA5A5A5A5);

        // x0 never written, never busy.
        cyc();
        idle();
        we_a_L = 0; rd_a = 0; wdata_a = 32'hFFFFFFFF;
        we_b_L = 0; rd_b = 0; wdata_b = 32'hFFFFFFFF;
        issue_L = 0; issue_rd = 0; rs1 = 0;
        mid();
        chk("x0_same", d1_r1, 32'h0);
        cyc();
        idle();
        mid();
        chk("x0_after", d1_r1, 32'h0);
        chk("x0_busy", 32'(d1_bv[0]), 32'h0);

        // Load to x9 issued at N, completes at N+3.
        cyc();
        issue_L = 0; issue_rd = 9; rs1 = 9;
        mid();
        chk("sb_N", 32'(d1_b1), 32'h0);
        cyc();
        idle();
        mid();
        chk("sb_N1", 32'(d1_b1), 32'h1);
        cyc();
        mid();
        chk("sb_N2", 32'(d1_b1), 32'h1);
        cyc();
        we_b_L = 0; rd_b = 9; wdata_b = 32'h42;
        mid();
        chk("sb_N3_busy", 32'(d1_b1), 32'h0);
        chk("sb_N3_data", d1_r1, 32'h42);
        chk("sb_N3_nobyp", 32'(d0_b1), 32'h1);
        cyc();
        idle();
        mid();
        chk("sb_N4_vec", 32'(d1_bv[9]), 32'h0);
        chk("sb_N4_data", d0_r1, 32'h42);

        // Issue and clear on x12 in the same cycle: set wins.
        cyc();
        issue_L = 0; issue_rd = 12;
        cyc();
        issue_L = 0; issue_rd = 12;
        we_b_L = 0; rd_b = 12; wdata_b = 32'h5;
        cyc();
        idle(); rs1 = 12;
        mid();
        chk("setwin_vec", 32'(d1_bv[12]), 32'h1);
        chk("setwin_data", d0_r1, 32'h5);

        // No-bypass latency on x4.
        cyc();
        idle(); we_a_L = 0; rd_a = 4; wdata_a = 32'h1234; rs1 = 4;
        mid();
        chk("nobyp_old", d0_r1, 32'h0);
        chk("byp_new", d1_r1, 32'h1234);
        cyc();
        idle();
        mid();
        chk("nobyp_next", d0_r1, 32'h1234);

        // Mid-sequence reset drops busy bits and a same-cycle load writeback.
        cyc();
        issue_L = 0; issue_rd = 9;
        cyc();
        idle(); reset = 0;
        we_b_L = 0; rd_b = 9; wdata_b = 32'h77; rs1 = 9; rs2 = 4;
        mid();
        chk("mrst_rd1", d1_r1, 32'h0);
        chk("mrst_busy", 32'(d1_b1), 32'h0);
        chk("mrst_vec", d1_bv, 32'h0);
        cyc();
        idle(); reset = 1;
        mid();
        chk("mrst_after_vec", d0_bv, 32'h0);
        chk("mrst_after_x9", d1_r1, 32'h0);
        chk("mrst_after_x4", d0_r2, 32'h0);

        // Random traffic; narrow address range half the time to force collisions.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            reset   = ($urandom_range(0, 49) != 0);
            we_a_L  = $urandom_range(0, 1);
            we_b_L  = $urandom_range(0, 1);
            issue_L = ($urandom_range(0, 2) != 0);
            wdata_a = $urandom;
            wdata_b = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                rd_a = AW'($urandom_range(0, 3)); rd_b = AW'($urandom_range(0, 3));
                issue_rd = AW'($urandom_range(0, 3));
                rs1 = AW'($urandom_range(0, 3)); rs2 = AW'($urandom_range(0, 3));
            end else begin
                rd_a = AW'($urandom); rd_b = AW'($urandom); issue_rd = AW'($urandom);
                rs1 = AW'($urandom); rs2 = AW'($urandom);
            end
        end

        cyc();
        idle();
        cyc();
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's single-write-port integer register file.
- Two write ports:
  - Port A: ALU/execute writeback.
  - Port B: load/memory writeback.
- Two asynchronous read ports with optional same-cycle write-to-read bypass.
- Per-register busy scoreboard: set when a load issues, cleared on its port-B writeback. Decode uses it to stall on RAW hazards against outstanding loads.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; power of two, ≥ 2.
- ADDR_W, $clog2(NUM_REGS), register index width (derived; not overridden).
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads see bank contents only.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- rd_a  in  ADDR_W  port A destination index.
- wdata_a  in  XLEN  port A write data.
- we_a_L  in  1  port A write enable, active-low.
- rd_b  in  ADDR_W  port B (load) destination index.
- wdata_b  in  XLEN  port B write data.
- we_b_L  in  1  port B write enable, active-low; also clears busy[rd_b].
- issue_rd  in  ADDR_W  destination of a load being issued.
- issue_L  in  1  load-issue strobe, active-low; sets busy[issue_rd].
- rs1  in  ADDR_W  read port 1 index.
- regData1  out  XLEN  read port 1 data.
- rs2  in  ADDR_W  read port 2 index.
- regData2  out  XLEN  read port 2 data.
- rs1_busy  out  1  rs1 has an outstanding load not satisfied this cycle.
- rs2_busy  out  1  same for rs2.
- busy_vec  out  NUM_REGS  raw scoreboard state, bit i = busy[i].

Behaviour:

Reset (reset==0 at posedge):
- All registers cleared to 0; all busy bits cleared.
- Writes, issues and bypass are ignored/suppressed while reset is low.
- While reset is low, regData1/2 = 0, rs1_busy/rs2_busy = 0, busy_vec = 0.
- Asserting reset mid-operation discards pending busy bits. A port-B write in that same cycle is dropped.

Register x0:
- Always reads 0 and is never written.
- busy[0] is never set; an issue with issue_rd==0 is ignored.

Writes (posedge):
- Port A writes when we_a_L==0 && rd_a!=0.
- Port B writes when we_b_L==0 && rd_b!=0.
- Both ports to the same rd in the same cycle: port A data wins.
- Writes to distinct registers both commit.

Scoreboard (posedge), per register r:
- Set if issue_L==0 && issue_rd==r && r!=0.
- Else cleared if we_b_L==0 && rd_b==r.
- Else hold.
- Issue and port-B clear to the same r in one cycle: set wins (a new load replaces the completing one).
- Port-A writes do not touch busy bits.

Reads (combinational, zero latency), for port n ∈ {1,2}:
- rsn==0 → 0.
- Else if BYPASS && write A hits rsn → wdata_a.
- Else if BYPASS && write B hits rsn → wdata_b.
- Else bank[rsn].
- With BYPASS==0, a written value is visible the cycle after the posedge.

Busy outputs:
- rsn_busy = busy[rsn] && !(BYPASS && we_b_L==0 && rd_b==rsn).
- A same-cycle issue to rsn does not raise rsn_busy until the next cycle.
- busy_vec reflects registered state only (no bypass).

Timing:
- Write latency 1 cycle.
- Busy set/clear visible on busy_vec 1 cycle after the strobe.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with we_a_L=0, rd_a=5, wdata_a=0xDEADBEEF → after release, reading rs1=5 gives 0 and busy_vec=0.
2. Dual write and bypass (BYPASS=1):
   - Same cycle: A writes x3=0x11111111, B writes x3=0x22222222, rs1=3 → regData1=0x11111111 in that cycle and after the posedge.
   - Separately: A writes x7=0xA5A5A5A5, rs2=7 → regData2=0xA5A5A5A5 combinationally in the same cycle.
3. x0: write x0=0xFFFFFFFF on both ports and issue_rd=0 → regData1 (rs1=0) stays 0 and busy_vec[0] stays 0.
4. Scoreboard:
   - Issue load to x9 (issue_L=0) at cycle N → rs1=9 gives rs1_busy=1 from N+1.
   - At cycle N+3, B writes x9=0x00000042 → rs1_busy=0 and regData1=0x42 in cycle N+3; busy_vec[9]=0 from N+4.
5. Simultaneous issue and clear: busy[12]=1, same cycle issue_rd=12 and rd_b=12 write 0x5 → next cycle busy_vec[12]=1 and bank[12]=0x5.
6. BYPASS=0 instance: A writes x4=0x1234 at cycle N with rs1=4 → regData1 shows the old value in N and 0x1234 in N+1. Repeat with a mid-sequence reset=0: busy bits and registers clear.
